// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: full-circle binary angle in, Q2.(WIDTH-2) cos/sin out.
// Define CORDIC_ROTATOR_ROUND_EN to round the shifted terms half-up instead of truncating.
module cordic_rotator #(
    parameter int WIDTH = 32,
    parameter int ITERS = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        angle_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] cos_out,
    output logic signed [WIDTH-1:0] sin_out
);

    localparam int CNT_W = $clog2(ITERS);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(ITERS - 1);
    localparam real PI = 3.141592653589793;
    localparam logic signed [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    function automatic logic signed [WIDTH-1:0] k_const();
        return WIDTH'($rtoi(0.6072529350088814 * (2.0 ** (WIDTH - 2)) + 0.5));
    endfunction

    // atan(2^-i) by its power series; t <= 0.5 for i >= 1 so 40 terms is far past double precision.
    function automatic logic signed [WIDTH-1:0] beta_f(input int i);
        real t, t2, term, sum;
        if (i == 0) begin
            sum = PI / 4.0;
        end else begin
            t    = 1.0 / (2.0 ** i);
            t2   = t * t;
            term = t;
            sum  = 0.0;
            for (int n = 0; n < 40; n++) begin
                if (n % 2 == 0) sum = sum + term / real'(2 * n + 1);
                else            sum = sum - term / real'(2 * n + 1);
                term = term * t2;
            end
        end
        return WIDTH'($rtoi(sum * (2.0 ** WIDTH) / (2.0 * PI) + 0.5));
    endfunction

    function automatic logic signed [WIDTH-1:0] shr(input logic signed [WIDTH-1:0] v,
                                                    input cnt_t sh);
`ifdef CORDIC_ROTATOR_ROUND_EN
        logic signed [WIDTH-1:0] r;
        if (sh == '0) return v;
        r = v >>> (sh - cnt_t'(1));
        return (r + ONE) >>> 1;
`else
        return v >>> sh;
`endif
    endfunction

    logic signed [WIDTH-1:0] beta_tab [ITERS];
    for (genvar g = 0; g < ITERS; g++) begin : g_beta
        localparam logic signed [WIDTH-1:0] B = beta_f(g);
        assign beta_tab[g] = B;
    end

    localparam logic signed [WIDTH-1:0] K = k_const();

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
    logic signed [WIDTH-1:0] xs, ys;
    cnt_t                    cnt_q, cnt_d;
    logic                    neg_q, neg_d;
    logic                    out_valid_q, out_valid_d;
    logic                    accept;

    always_comb begin
        in_ready    = (state_q == IDLE) || (state_q == DONE && out_ready);
        accept      = in_valid && in_ready;
        xs          = shr(x_q, cnt_q);
        ys          = shr(y_q, cnt_q);
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ROTATE: begin
                if (!z_q[WIDTH-1]) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - beta_tab[cnt_q];
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + beta_tab[cnt_q];
                end
                cnt_d = cnt_q + cnt_t'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cos_d       = neg_q ? -x_d : x_d;
                    sin_d       = neg_q ? -y_d : y_d;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Quadrants 1 and 2 are folded by a half-turn (MSB flip) and the result negated.
        if (accept) begin
            neg_d   = angle_in[WIDTH-1] ^ angle_in[WIDTH-2];
            z_d     = {angle_in[WIDTH-1] ^ neg_d, angle_in[WIDTH-2:0]};
            x_d     = K;
            y_d     = '0;
            cnt_d   = '0;
            state_d = ROTATE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Bench for cordic_rotator: directed angles, back-pressure, mid-rotation reset and a random sweep
// checked against real-valued cos/sin.
module tb_cordic_rotator;

    localparam int WIDTH = 32;
    localparam int ITERS = 30;
`ifdef CORDIC_ROTATOR_ROUND_EN
    localparam int TOL = ITERS / 2 + 2;
`else
    localparam int TOL = ITERS + 2;
`endif
    localparam real PI = 3.141592653589793;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [WIDTH-1:0]        angle_in = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;

    int checks = 0;
    int errors = 0;

    cordic_rotator #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [WIDTH-1:0] obs, input real ideal);
        real  d;
        logic ok;
        d = real'(obs) - ideal;
        if (d < 0.0) d = -d;
        ok = (d <= real'(TOL));
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0.1f (tol %0d)", tag, obs, ideal, TOL);
        end
    endtask

    task automatic check_vals(input logic [WIDTH-1:0] a, input string tag);
        real th;
        th = real'(a) * 2.0 * PI / (2.0 ** WIDTH);
        chk_near({tag, "_cos"}, cos_out, $cos(th) * (2.0 ** (WIDTH - 2)));
        chk_near({tag, "_sin"}, sin_out, $sin(th) * (2.0 ** (WIDTH - 2)));
    endtask

    // Present an angle and return just after the edge that accepts it.
    task automatic send(input logic [WIDTH-1:0] a);
        int n = 0;
        in_valid = 1'b1;
        angle_in = a;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk_bit("accept_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk_bit("busy_ready", in_ready, 1'b0);
    endtask

    task automatic wait_result(input logic [WIDTH-1:0] a, input string tag);
        int n = 0;
        while (!out_valid && n < ITERS + 20) begin
            step();
            n++;
        end
        chk_int({tag, "_latency"}, n, ITERS);
        check_vals(a, tag);
    endtask

    logic [WIDTH-1:0] dir [9] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'h2000_0000,
                                  32'hE000_0000, 32'hFFFF_FFFF, 32'hC000_0000, 32'h6000_0000,
                                  32'hA000_0000};

    initial begin
        logic [WIDTH-1:0] hc, hs, a;

        step();
        step();
        chk_bit ("rst_out_valid", out_valid, 1'b0);
        chk_bit ("rst_in_ready",  in_ready,  1'b1);
        chk_word("rst_cos",       cos_out,   '0);
        chk_word("rst_sin",       sin_out,   '0);
        rst_n = 1'b1;
        step();

        foreach (dir[i]) begin
            send(dir[i]);
            wait_result(dir[i], "dir");
            step();
            chk_bit("dir_release", out_valid, 1'b0);
        end

        // Stall the consumer with a second angle pending.
        out_ready = 1'b0;
        send(32'h2000_0000);
        wait_result(32'h2000_0000, "bp");
        hc = cos_out;
        hs = sin_out;
        in_valid = 1'b1;
        angle_in = 32'hA000_0000;
        for (int k = 0; k < 10; k++) begin
            step();
            chk_word("bp_hold_cos", cos_out, hc);
            chk_word("bp_hold_sin", sin_out, hs);
            chk_bit ("bp_hold_vld", out_valid, 1'b1);
            chk_bit ("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk_bit("bp_release_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk_bit("bp_vld_drop", out_valid, 1'b0);
        wait_result(32'hA000_0000, "bp2");
        step();

        // Reset while cnt has reached 12.
        send(32'h6000_0000);
        repeat (12) step();
        rst_n = 1'b0;
        #1;
        chk_bit ("mid_rst_vld",   out_valid, 1'b0);
        chk_word("mid_rst_cos",   cos_out,   '0);
        chk_word("mid_rst_sin",   sin_out,   '0);
        chk_bit ("mid_rst_ready", in_ready,  1'b1);
        repeat (3) step();
        chk_bit("mid_rst_hold_vld", out_valid, 1'b0);
        rst_n = 1'b1;
        step();
        chk_bit("post_rst_vld", out_valid, 1'b0);
        send(32'h4000_0000);
        wait_result(32'h4000_0000, "post_rst");

        // Back-to-back random angles: each new angle is accepted in the result cycle.
        a = $urandom;
        send(a);
        for (int k = 0; k < 1200; k++) begin
            wait_result(a, "rnd");
            a = $urandom;
            if (k < 1199) send(a);
        end
        step();
        chk_bit("final_idle_vld", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
